sd_init_seq: RTL and testbench

- Card-initialisation sequencer for the SD command engine: the block that issues the engine's start/cmd/arg/precnt/clkdiv and consumes its done/timeout/syntaxe/resparg.
- Runs the SD power-up sequence CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7, CMD16.
- Then switches the engine to the fast clock and reports card type and RCA to the sector reader.

---
 rtl/sd_init_seq_if.sv | 24 ++
 rtl/sd_init_seq.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_sd_init_seq.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_init_seq_if.sv
// Bus between the card-initialisation sequencer (master) and the SD command
// engine (slave): command issue fields out, completion status and response in.
interface sd_init_seq_if;
  logic [15:0] cmd_clkdiv;
  logic        cmd_start;
  logic [15:0] cmd_precnt;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_busy;
  logic        cmd_done;
  logic        cmd_timeout;
  logic        cmd_syntaxe;
  logic [31:0] cmd_resparg;

  modport master (
    output cmd_clkdiv, cmd_start, cmd_precnt, cmd_idx, cmd_arg,
    input  cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe, cmd_resparg
  );

  modport slave (
    input  cmd_clkdiv, cmd_start, cmd_precnt, cmd_idx, cmd_arg,
    output cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe, cmd_resparg
  );
endinterface

// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer. Walks CMD0, CMD8, the CMD55/ACMD41 loop,
// CMD2, CMD3, CMD7 and CMD16 through the command engine at the slow
// identification clock, then switches the engine to the fast clock and
// publishes card type and RCA. A failed step aborts with an error code.
module sd_init_seq #(
  parameter logic [15:0] SLOW_DIV    = 16'd63,
  parameter logic [15:0] FAST_DIV    = 16'd1,
  parameter logic [15:0] PRE_INIT    = 16'd80,
  parameter logic [15:0] PRE_CMD     = 16'd8,
  parameter logic [15:0] ACMD41_MAX  = 16'd1000,
  parameter logic [2:0]  CMD_RETRIES = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_code,
  output logic [1:0]  card_type,
  output logic [15:0] rca,
  sd_init_seq_if.master cmd
);

  // Phase of the current command (or terminal reporting state).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_READY = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Which command of the power-up sequence is being worked on.
  typedef enum logic [2:0] {
    STEP_CMD0   = 3'd0,
    STEP_CMD8   = 3'd1,
    STEP_CMD55  = 3'd2,
    STEP_ACMD41 = 3'd3,
    STEP_CMD2   = 3'd4,
    STEP_CMD3   = 3'd5,
    STEP_CMD7   = 3'd6,
    STEP_CMD16  = 3'd7
  } step_t;

  state_t      r_state, w_state;
  step_t       r_step, w_step;
  logic [2:0]  r_retry, w_retry;
  logic [15:0] r_loop, w_loop;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic [3:0]  r_code, w_code;
  logic [1:0]  r_type, w_type;
  logic [15:0] r_rca, w_rca;
  logic [15:0] r_clkdiv, w_clkdiv;
  logic        r_start, w_start;
  logic [15:0] r_precnt, w_precnt;
  logic [5:0]  r_idx, w_idx;
  logic [31:0] r_arg, w_arg;

  logic        w_to;
  logic        w_syn;
  logic        w_fail;
  logic        w_advance;
  logic        w_retry_req;
  logic [15:0] w_loop_inc;
  logic        w_unused_resp;

  function automatic logic [5:0] step_idx(input step_t s);
    case (s)
      STEP_CMD0:   step_idx = 6'd0;
      STEP_CMD8:   step_idx = 6'd8;
      STEP_CMD55:  step_idx = 6'd55;
      STEP_ACMD41: step_idx = 6'd41;
      STEP_CMD2:   step_idx = 6'd2;
      STEP_CMD3:   step_idx = 6'd3;
      STEP_CMD7:   step_idx = 6'd7;
      STEP_CMD16:  step_idx = 6'd16;
      default:     step_idx = 6'd0;
    endcase
  endfunction

  // HCS bit in ACMD41 is only offered to cards that answered CMD8.
  function automatic logic [31:0] step_arg(input step_t s, input logic [1:0] ctype,
                                           input logic [15:0] crca);
    case (s)
      STEP_CMD8:   step_arg = 32'h0000_01AA;
      STEP_ACMD41: step_arg = (ctype == 2'd2) ? 32'h4010_0000 : 32'h0010_0000;
      STEP_CMD7:   step_arg = {crca, 16'h0000};
      STEP_CMD16:  step_arg = 32'd512;
      default:     step_arg = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] step_err(input step_t s);
    case (s)
      STEP_CMD8:   step_err = 4'd1;
      STEP_CMD55:  step_err = 4'd2;
      STEP_ACMD41: step_err = 4'd3;
      STEP_CMD2:   step_err = 4'd4;
      STEP_CMD3:   step_err = 4'd5;
      STEP_CMD7:   step_err = 4'd6;
      STEP_CMD16:  step_err = 4'd7;
      default:     step_err = 4'd0;
    endcase
  endfunction

  function automatic step_t step_next(input step_t s);
    case (s)
      STEP_CMD0:   step_next = STEP_CMD8;
      STEP_CMD8:   step_next = STEP_CMD55;
      STEP_CMD55:  step_next = STEP_ACMD41;
      STEP_ACMD41: step_next = STEP_CMD2;
      STEP_CMD2:   step_next = STEP_CMD3;
      STEP_CMD3:   step_next = STEP_CMD7;
      STEP_CMD7:   step_next = STEP_CMD16;
      default:     step_next = STEP_CMD16;
    endcase
  endfunction

  // Completion classification; timeout dominates a simultaneous syntax error.
  assign w_to          = cmd.cmd_timeout;
  assign w_syn         = cmd.cmd_syntaxe & ~cmd.cmd_timeout;
  assign w_fail        = w_to | w_syn;
  assign w_loop_inc    = (r_loop == 16'hFFFF) ? r_loop : r_loop + 16'd1;
  assign w_unused_resp = ^{cmd.cmd_resparg[29:16], cmd.cmd_resparg[15:12]};

  // Next-state and next-output computation for the whole sequence.
  always_comb begin
    w_state     = r_state;
    w_step      = r_step;
    w_retry     = r_retry;
    w_loop      = r_loop;
    w_busy      = r_busy;
    w_done      = r_done;
    w_err       = r_err;
    w_code      = r_code;
    w_type      = r_type;
    w_rca       = r_rca;
    w_clkdiv    = r_clkdiv;
    w_start     = 1'b0;
    w_precnt    = r_precnt;
    w_idx       = r_idx;
    w_arg       = r_arg;
    w_advance   = 1'b0;
    w_retry_req = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (init_req) begin
          w_done   = 1'b0;
          w_err    = 1'b0;
          w_code   = 4'd0;
          w_type   = 2'd0;
          w_rca    = 16'd0;
          w_clkdiv = SLOW_DIV;
          w_busy   = 1'b1;
          w_step   = STEP_CMD0;
          w_retry  = 3'd0;
          w_loop   = 16'd0;
          w_state  = S_ISSUE;
        end else begin
          w_state = S_IDLE;
        end
      end

      S_ISSUE: begin
        // The engine stays busy a cycle after done; hold the next start until it clears.
        if (!cmd.cmd_busy) begin
          w_start  = 1'b1;
          w_idx    = step_idx(r_step);
          w_arg    = step_arg(r_step, r_type, r_rca);
          w_precnt = (r_step == STEP_CMD0) ? PRE_INIT : PRE_CMD;
          w_state  = S_WAIT;
        end else begin
          w_state = S_ISSUE;
        end
      end

      S_WAIT: begin
        if (cmd.cmd_done) begin
          case (r_step)
            STEP_CMD0: begin
              // No response is expected from CMD0; any completion moves on.
              w_advance = 1'b1;
            end
            STEP_CMD8: begin
              if (w_to) begin
                w_type    = 2'd1;
                w_advance = 1'b1;
              end else if (w_syn) begin
                w_retry_req = 1'b1;
              end else if (cmd.cmd_resparg[11:0] == 12'h1AA) begin
                w_type    = 2'd2;
                w_advance = 1'b1;
              end else begin
                w_state = S_ERR;
              end
            end
            STEP_ACMD41: begin
              // R3 carries no valid command index, so syntax errors are ignored here.
              if (w_to) begin
                w_state = S_ERR;
              end else if (cmd.cmd_resparg[31]) begin
                if (cmd.cmd_resparg[30]) begin
                  w_type = 2'd3;
                end else begin
                  w_type = r_type;
                end
                w_advance = 1'b1;
              end else begin
                w_retry = 3'd0;
                w_loop  = w_loop_inc;
                if (w_loop_inc >= ACMD41_MAX) begin
                  w_state = S_ERR;
                end else begin
                  w_step  = STEP_CMD55;
                  w_state = S_ISSUE;
                end
              end
            end
            STEP_CMD3: begin
              if (w_fail) begin
                w_retry_req = 1'b1;
              end else begin
                w_rca     = cmd.cmd_resparg[31:16];
                w_advance = 1'b1;
              end
            end
            STEP_CMD55, STEP_CMD2, STEP_CMD7, STEP_CMD16: begin
              if (w_fail) begin
                w_retry_req = 1'b1;
              end else begin
                w_advance = 1'b1;
              end
            end
            default: begin
              w_state = S_ERR;
            end
          endcase
        end else begin
          w_state = S_WAIT;
        end
      end

      S_READY: begin
        w_clkdiv = FAST_DIV;
        w_done   = 1'b1;
        w_busy   = 1'b0;
        w_state  = S_IDLE;
      end

      S_ERR: begin
        w_err   = 1'b1;
        w_code  = step_err(r_step);
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_advance) begin
      w_retry = 3'd0;
      if (r_step == STEP_CMD16) begin
        w_state = S_READY;
      end else begin
        w_step  = step_next(r_step);
        w_state = S_ISSUE;
      end
    end else if (w_retry_req) begin
      if (r_retry < CMD_RETRIES) begin
        w_retry = r_retry + 3'd1;
        w_state = S_ISSUE;
      end else begin
        w_state = S_ERR;
      end
    end else begin
      w_retry = w_retry;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_step   <= STEP_CMD0;
      r_retry  <= 3'd0;
      r_loop   <= 16'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= 4'd0;
      r_type   <= 2'd0;
      r_rca    <= 16'd0;
      r_clkdiv <= SLOW_DIV;
      r_start  <= 1'b0;
      r_precnt <= 16'd0;
      r_idx    <= 6'd0;
      r_arg    <= 32'd0;
    end else begin
      r_state  <= w_state;
      r_step   <= w_step;
      r_retry  <= w_retry;
      r_loop   <= w_loop;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_code   <= w_code;
      r_type   <= w_type;
      r_rca    <= w_rca;
      r_clkdiv <= w_clkdiv;
      r_start  <= w_start;
      r_precnt <= w_precnt;
      r_idx    <= w_idx;
      r_arg    <= w_arg;
    end
  end

  assign init_busy      = r_busy;
  assign init_done      = r_done;
  assign init_err       = r_err;
  assign err_code       = r_code;
  assign card_type      = r_type;
  assign rca            = r_rca;
  assign cmd.cmd_clkdiv = r_clkdiv;
  // A reset in flight must cancel a pending start within the same cycle.
  assign cmd.cmd_start  = r_start & ~rst;
  assign cmd.cmd_precnt = r_precnt;
  assign cmd.cmd_idx    = r_idx;
  assign cmd.cmd_arg    = r_arg;

endmodule

// File: tb/tb_sd_init_seq.sv
// Bench for sd_init_seq: a scripted command-engine model plays back the
// transaction list that a card-level reference model expects for each
// randomized card profile, and checks every issued command and the result.
module tb_sd_init_seq;
  localparam logic [15:0] SLOW_DIV   = 16'd63;
  localparam logic [15:0] FAST_DIV   = 16'd1;
  localparam logic [15:0] PRE_INIT   = 16'd80;
  localparam logic [15:0] PRE_CMD    = 16'd8;
  localparam int          ACMD41_MAX = 1000;
  localparam int          ATTEMPTS   = 4;

  logic        clk;
  logic        rst;
  logic        init_req;
  logic        init_busy;
  logic        init_done;
  logic        init_err;
  logic [3:0]  err_code;
  logic [1:0]  card_type;
  logic [15:0] rca;

  sd_init_seq_if u_if ();

  sd_init_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .init_busy (init_busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_code  (err_code),
    .card_type (card_type),
    .rca       (rca),
    .cmd       (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [15:0] pre;
    logic        to;
    logic        syn;
    logic [31:0] resp;
  } txn_t;

  txn_t        exp_q[$];
  int          total;
  int          bad;
  string       cur_name;
  logic        exp_done;
  logic        exp_err;
  logic [3:0]  exp_code;
  logic [1:0]  exp_type;
  logic [15:0] exp_rca;

  // Card profile: 0 none, 1 SDv1, 2 SDv2 byte, 3 SDHC, 4 bad CMD8 echo.
  int          p_kind;
  int          p_fail[8];
  int          p_nb;
  bit          p_acmd_to;
  logic [15:0] p_rca;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s/%s got=%h want=%h", cur_name, tag, got, want);
    end
  endtask

  task automatic push(input logic [5:0] idx, input logic [31:0] arg, input logic to,
                      input logic syn, input logic [31:0] resp);
    txn_t t;
    t.idx  = idx;
    t.arg  = arg;
    t.pre  = (idx == 6'd0) ? PRE_INIT : PRE_CMD;
    t.to   = to;
    t.syn  = syn;
    t.resp = resp;
    exp_q.push_back(t);
  endtask

  // One command with nfail failed completions before a good one; ok=0 when
  // all attempts (first try plus retries) are used up.
  task automatic attempt(input logic [5:0] idx, input logic [31:0] arg, input int nfail,
                         input bit only_to, input bit only_syn, input logic [31:0] okresp,
                         output bit ok);
    int n;
    int m;
    n = (nfail > ATTEMPTS) ? ATTEMPTS : nfail;
    for (int i = 0; i < n; i++) begin
      m = only_to ? 1 : (only_syn ? 2 : int'($urandom_range(1, 3)));
      push(idx, arg, m[0], m[1], $urandom);
    end
    ok = (nfail < ATTEMPTS);
    if (ok) push(idx, arg, 1'b0, 1'b0, okresp);
  endtask

  task automatic model_err(input logic [3:0] code);
    exp_err  = 1'b1;
    exp_code = code;
  endtask

  // Reference: expected command stream and final result for the profile.
  task automatic build_model();
    bit          ok;
    logic [31:0] a;
    logic [31:0] r;
    int          it;
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_code = 4'd0; exp_type = 2'd0; exp_rca = 16'd0;
    push(6'd0, 32'd0, 1'b1, 1'b0, $urandom);
    if (p_kind <= 1) begin
      push(6'd8, 32'h1AA, 1'b1, 1'($urandom_range(0, 1)), $urandom);
      exp_type = 2'd1;
    end else if (p_kind == 4) begin
      push(6'd8, 32'h1AA, 1'b0, 1'b0, 32'h0000_01AB);
      model_err(4'd1);
      return;
    end else begin
      r = $urandom;
      r[11:0] = 12'h1AA;
      attempt(6'd8, 32'h1AA, p_fail[1], 1'b0, 1'b1, r, ok);
      if (!ok) begin model_err(4'd1); return; end
      exp_type = 2'd2;
    end
    it = 0;
    forever begin
      attempt(6'd55, 32'd0, (p_kind == 0) ? ATTEMPTS : ((it == 0) ? p_fail[2] : 0),
              p_kind == 0, 1'b0, 32'h0000_0120, ok);
      if (!ok) begin model_err(4'd2); return; end
      a = (exp_type == 2'd2) ? 32'h4010_0000 : 32'h0010_0000;
      if (p_acmd_to) begin
        push(6'd41, a, 1'b1, 1'($urandom_range(0, 1)), $urandom);
        model_err(4'd3);
        return;
      end
      if (it < p_nb) begin
        r = $urandom;
        r[31] = 1'b0;
        push(6'd41, a, 1'b0, 1'($urandom_range(0, 1)), r);
        it++;
        if (it >= ACMD41_MAX) begin model_err(4'd3); return; end
      end else begin
        r = (p_kind == 3) ? 32'hC0FF_8000 : 32'h80FF_8000;
        push(6'd41, a, 1'b0, 1'($urandom_range(0, 1)), r);
        if (r[30]) exp_type = 2'd3;
        break;
      end
    end
    attempt(6'd2, 32'd0, p_fail[4], 1'b0, 1'b0, $urandom, ok);
    if (!ok) begin model_err(4'd4); return; end
    attempt(6'd3, 32'd0, p_fail[5], 1'b0, 1'b0, {p_rca, 16'h0500}, ok);
    if (!ok) begin model_err(4'd5); return; end
    exp_rca = p_rca;
    attempt(6'd7, {p_rca, 16'h0000}, p_fail[6], 1'b0, 1'b0, 32'h0000_0700, ok);
    if (!ok) begin model_err(4'd6); return; end
    attempt(6'd16, 32'd512, p_fail[7], 1'b0, 1'b0, 32'h0000_0900, ok);
    if (!ok) begin model_err(4'd7); return; end
    exp_done = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    cur_name = tag;
    check_eq("busy", 32'(init_busy), 32'd0);
    check_eq("done", 32'(init_done), 32'd0);
    check_eq("err", 32'(init_err), 32'd0);
    check_eq("code", 32'(err_code), 32'd0);
    check_eq("type", 32'(card_type), 32'd0);
    check_eq("rca", 32'(rca), 32'd0);
    check_eq("clkdiv", 32'(u_if.cmd_clkdiv), 32'(SLOW_DIV));
    check_eq("start", 32'(u_if.cmd_start), 32'd0);
    check_eq("precnt", 32'(u_if.cmd_precnt), 32'd0);
    check_eq("idx", 32'(u_if.cmd_idx), 32'd0);
    check_eq("arg", u_if.cmd_arg, 32'd0);
  endtask

  // Engine side of one command: wait for start, check it, answer per script.
  task automatic play_txn(input txn_t t, input bit rst_here, output bit aborted);
    int n;
    int lat;
    aborted = 1'b0;
    n = 0;
    while (u_if.cmd_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (u_if.cmd_start !== 1'b1) begin
      check_eq("start_seen", 32'd0, 32'd1);
      aborted = 1'b1;
      return;
    end
    check_eq("idx", 32'(u_if.cmd_idx), 32'(t.idx));
    check_eq("arg", u_if.cmd_arg, t.arg);
    check_eq("precnt", 32'(u_if.cmd_precnt), 32'(t.pre));
    if (rst_here) begin
      rst = 1'b1;
      #1;
      check_eq("start_drop_rst", 32'(u_if.cmd_start), 32'd0);
      aborted = 1'b1;
      return;
    end
    u_if.cmd_busy = 1'b1;
    @(negedge clk);
    check_eq("start_1cyc", 32'(u_if.cmd_start), 32'd0);
    if ($urandom_range(0, 7) == 0) init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    lat = $urandom_range(0, 3);
    repeat (lat) @(negedge clk);
    check_eq("idx_hold", 32'(u_if.cmd_idx), 32'(t.idx));
    check_eq("arg_hold", u_if.cmd_arg, t.arg);
    u_if.cmd_done    = 1'b1;
    u_if.cmd_timeout = t.to;
    u_if.cmd_syntaxe = t.syn;
    u_if.cmd_resparg = t.resp;
    @(negedge clk);
    u_if.cmd_done    = 1'b0;
    u_if.cmd_timeout = 1'b0;
    u_if.cmd_syntaxe = 1'b0;
    u_if.cmd_resparg = 32'd0;
    check_eq("no_start_busy", 32'(u_if.cmd_start), 32'd0);
    @(negedge clk);
    check_eq("no_start_busy", 32'(u_if.cmd_start), 32'd0);
    u_if.cmd_busy = 1'b0;
  endtask

  task automatic run_profile(input string name, input bit rst_at_acmd);
    bit ab;
    int n;
    build_model();
    cur_name = name;
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    check_eq("busy_req", 32'(init_busy), 32'd1);
    check_eq("done_clr", 32'(init_done), 32'd0);
    check_eq("err_clr", 32'(init_err), 32'd0);
    check_eq("type_clr", 32'(card_type), 32'd0);
    check_eq("rca_clr", 32'(rca), 32'd0);
    check_eq("clk_slow", 32'(u_if.cmd_clkdiv), 32'(SLOW_DIV));
    ab = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      play_txn(exp_q[i], rst_at_acmd && (exp_q[i].idx == 6'd41), ab);
      if (ab) break;
    end
    if (ab) begin
      rst = 1'b1;
      u_if.cmd_busy = 1'b0;
      @(negedge clk);
      if (rst_at_acmd) check_reset_outputs({name, "_rst"});
      rst = 1'b0;
      return;
    end
    n = 0;
    while (init_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      check_eq("no_extra_start", 32'(u_if.cmd_start), 32'd0);
      n++;
    end
    check_eq("busy_end", 32'(init_busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("start_idle", 32'(u_if.cmd_start), 32'd0);
    check_eq("done", 32'(init_done), 32'(exp_done));
    check_eq("err", 32'(init_err), 32'(exp_err));
    check_eq("code", 32'(err_code), 32'(exp_code));
    check_eq("type", 32'(card_type), 32'(exp_type));
    check_eq("rca", 32'(rca), 32'(exp_rca));
    check_eq("clkdiv", 32'(u_if.cmd_clkdiv), exp_done ? 32'(FAST_DIV) : 32'(SLOW_DIV));
  endtask

  task automatic set_profile(input int kind, input int nb, input bit acmd_to,
                             input logic [15:0] r);
    p_kind    = kind;
    p_nb      = nb;
    p_acmd_to = acmd_to;
    p_rca     = r;
    for (int s = 0; s < 8; s++) p_fail[s] = 0;
  endtask

  initial begin
    int k;
    total = 0;
    bad   = 0;
    cur_name = "por";
    rst = 1'b1;
    init_req = 1'b0;
    u_if.cmd_busy = 1'b0;
    u_if.cmd_done = 1'b0;
    u_if.cmd_timeout = 1'b0;
    u_if.cmd_syntaxe = 1'b0;
    u_if.cmd_resparg = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 32'(init_busy), 32'd0);

    set_profile(3, 0, 1'b0, 16'hAAAA);  run_profile("sdhc", 1'b0);
    set_profile(1, 0, 1'b0, 16'h1234);  run_profile("sdv1", 1'b0);
    set_profile(2, 3, 1'b0, 16'h5678);  run_profile("v2_busy3", 1'b0);
    set_profile(0, 0, 1'b0, 16'h0000);  run_profile("nocard", 1'b0);
    set_profile(4, 0, 1'b0, 16'h0000);  run_profile("bad_echo", 1'b0);
    set_profile(3, 2, 1'b0, 16'hAAAA);  run_profile("rst_acmd41", 1'b1);
    set_profile(3, 0, 1'b0, 16'hBEEF);  run_profile("after_rst", 1'b0);
    set_profile(2, 0, 1'b0, 16'h0042);
    p_fail[4] = 3; p_fail[5] = 3;       run_profile("retry_clear", 1'b0);
    set_profile(2, 0, 1'b0, 16'h0042);
    p_fail[7] = 4;                      run_profile("cmd16_exhaust", 1'b0);
    set_profile(2, ACMD41_MAX, 1'b0, 16'h0007);  run_profile("acmd41_max", 1'b0);

    for (int r = 0; r < 24; r++) begin
      k = $urandom_range(0, 9);
      set_profile((k == 0) ? 0 : (k <= 2) ? 1 : (k <= 5) ? 2 : (k <= 8) ? 3 : 4,
                  $urandom_range(0, 4), ($urandom_range(0, 9) == 0), 16'($urandom));
      for (int s = 0; s < 8; s++)
        p_fail[s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_profile($sformatf("rand%0d", r), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
